// File: rtl/bp_be_scoreboard_detector.sv
// ============================================================================
// bp_be_scoreboard_detector
//
// Issue-stage hazard detector for a backend with fixed-latency pipes and
// variable-latency ("long") units. Each architectural register (int and fp
// classes) owns a countdown of cycles until its in-flight result becomes
// forwardable, plus a long-pending bit that stays set until the long unit
// writes the register back.
//
// Ports
//   clk_i            clock
//   reset_n_i        synchronous active-low reset
//   isd_v_i          issue-stage instruction valid
//   isd_rs_v_i       per-source read valid {rs3, rs2, rs1}
//   isd_rs_fp_i      per-source register class (1 = fp)
//   isd_rs_addr_i    source addresses, rs1 in the LSBs
//   isd_rd_v_i       destination write valid
//   isd_rd_fp_i      destination register class
//   isd_rd_addr_i    destination address
//   isd_lat_i        fixed result latency; 0 = long op
//   isd_serial_i     instruction needs an empty scoreboard
//   stall_i          external structural stall
//   flush_i          kill all in-flight fixed-latency ops
//   long_wb_v_i      long-op writeback valid
//   long_wb_fp_i     long-op writeback register class
//   long_wb_addr_i   long-op writeback address
//   dispatch_v_o     instruction may dispatch this cycle (combinational)
//   long_busy_o      at least one long op outstanding (registered state)
//   empty_o          nothing in flight at all (registered state)
// ============================================================================
module bp_be_scoreboard_detector #(
    parameter int num_regs_p  = 32,
    parameter int lat_width_p = 3,
    parameter int max_long_p  = 4,
    localparam int reg_addr_width_lp = $clog2(num_regs_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           isd_v_i,
    input  logic [2:0]                     isd_rs_v_i,
    input  logic [2:0]                     isd_rs_fp_i,
    input  logic [3*reg_addr_width_lp-1:0] isd_rs_addr_i,
    input  logic                           isd_rd_v_i,
    input  logic                           isd_rd_fp_i,
    input  logic [reg_addr_width_lp-1:0]   isd_rd_addr_i,
    input  logic [lat_width_p-1:0]         isd_lat_i,
    input  logic                           isd_serial_i,
    input  logic                           stall_i,
    input  logic                           flush_i,
    input  logic                           long_wb_v_i,
    input  logic                           long_wb_fp_i,
    input  logic [reg_addr_width_lp-1:0]   long_wb_addr_i,
    output logic                           dispatch_v_o,
    output logic                           long_busy_o,
    output logic                           empty_o
);

    // Entry index is {class, addr}: int registers occupy the lower half,
    // fp registers the upper half.
    localparam int entry_width_lp    = reg_addr_width_lp + 1;
    localparam int entries_lp        = 2 * num_regs_p;
    localparam int long_cnt_width_lp = $clog2(max_long_p + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [lat_width_p-1:0]       cnt_reg  [entries_lp];
    logic [lat_width_p-1:0]       cnt_next [entries_lp];
    logic [entries_lp-1:0]        lp_reg;
    logic [entries_lp-1:0]        lp_next;
    logic [long_cnt_width_lp-1:0] long_cnt_reg;
    logic [long_cnt_width_lp-1:0] long_cnt_next;

    // ------------------------------------------------------------------
    // Decoded issue-stage fields
    // ------------------------------------------------------------------
    logic [entry_width_lp-1:0] rs_entry [3];
    logic [2:0]                rs_tracked;
    logic [2:0]                raw_vec;

    logic [entry_width_lp-1:0] rd_entry;
    logic                      rd_tracked;
    logic                      rd_long;
    logic [entry_width_lp-1:0] wb_entry;
    logic                      wb_dec;

    logic raw_hazard;
    logic waw_hazard;
    logic cap_hazard;
    logic serial_hazard;
    logic long_full;
    logic dispatch_event;
    logic load_fixed;
    logic load_long;

    // Per-entry status and update vectors
    logic [entries_lp-1:0] cnt_nz_vec;
    logic [entries_lp-1:0] wb_hit_vec;
    logic [entries_lp-1:0] lp_live_vec;
    logic [entries_lp-1:0] load_fixed_vec;
    logic [entries_lp-1:0] load_long_vec;

    assign rd_entry = {isd_rd_fp_i, isd_rd_addr_i};
    assign wb_entry = {long_wb_fp_i, long_wb_addr_i};

    // Int x0 is hardwired zero: it is never written into the scoreboard
    // and never checked as a source. Fp register 0 is an ordinary register.
    assign rd_tracked = isd_rd_v_i & (isd_rd_fp_i | (|isd_rd_addr_i));
    assign rd_long    = rd_tracked & ~(|isd_lat_i);

    // ------------------------------------------------------------------
    // Per-entry logic
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < entries_lp; gi++) begin : g_entry
            assign cnt_nz_vec[gi]     = |cnt_reg[gi];
            assign wb_hit_vec[gi]     = long_wb_v_i & (wb_entry == entry_width_lp'(gi));
            // A pending bit being cleared by this cycle's writeback no
            // longer blocks readers or writers: the value is on the bypass.
            assign lp_live_vec[gi]    = lp_reg[gi] & ~wb_hit_vec[gi];
            assign load_fixed_vec[gi] = load_fixed & (rd_entry == entry_width_lp'(gi));
            assign load_long_vec[gi]  = load_long  & (rd_entry == entry_width_lp'(gi));

            // Flush wins over everything (it also blocks dispatch, so no
            // load can coincide with it); otherwise load or count down.
            assign cnt_next[gi] = flush_i            ? '0 :
                                  load_fixed_vec[gi] ? isd_lat_i :
                                  cnt_nz_vec[gi]     ? cnt_reg[gi] - lat_width_p'(1) :
                                                       '0;

            // A new long op to an entry whose writeback lands this same
            // cycle must leave the bit set: set takes priority over clear.
            assign lp_next[gi] = load_long_vec[gi] | lp_live_vec[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // RAW: per-source check. cnt == 1 means the result is available on
    // the forwarding path next cycle, so only cnt > 1 stalls.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_src
            assign rs_entry[gi]   = {isd_rs_fp_i[gi],
                                     isd_rs_addr_i[gi*reg_addr_width_lp +: reg_addr_width_lp]};
            assign rs_tracked[gi] = isd_rs_fp_i[gi]
                                  | (|isd_rs_addr_i[gi*reg_addr_width_lp +: reg_addr_width_lp]);
            assign raw_vec[gi]    = isd_rs_v_i[gi] & rs_tracked[gi]
                                  & ((cnt_reg[rs_entry[gi]] > lat_width_p'(1))
                                     | lp_live_vec[rs_entry[gi]]);
        end
    endgenerate

    assign raw_hazard = |raw_vec;

    // WAW: a fixed op may overtake an older in-flight write only if it
    // lands no earlier; a long op's completion time is unknown, so any
    // live long-pending destination blocks.
    assign waw_hazard = rd_tracked
                      & (lp_live_vec[rd_entry]
                         | (~rd_long & (cnt_reg[rd_entry] > isd_lat_i)));

    // Capacity is judged on the registered count only; a writeback in the
    // same cycle frees its slot from the next cycle on.
    assign long_full  = (long_cnt_reg == long_cnt_width_lp'(max_long_p));
    assign cap_hazard = rd_long & long_full;

    assign serial_hazard = isd_serial_i & ~empty_o;

    assign dispatch_v_o = reset_n_i
                        & ~(raw_hazard | waw_hazard | cap_hazard
                            | serial_hazard | stall_i | flush_i);

    assign dispatch_event = isd_v_i & dispatch_v_o;
    assign load_fixed     = dispatch_event & rd_tracked & ~rd_long;
    assign load_long      = dispatch_event & rd_long;

    // Writebacks to entries with no pending long op are ignored, which
    // keeps the outstanding count from underflowing.
    assign wb_dec = long_wb_v_i & lp_reg[wb_entry];

    always_comb begin
        long_cnt_next = long_cnt_reg;
        case ({load_long, wb_dec})
            2'b10:   long_cnt_next = long_cnt_reg + long_cnt_width_lp'(1);
            2'b01:   long_cnt_next = long_cnt_reg - long_cnt_width_lp'(1);
            default: long_cnt_next = long_cnt_reg;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < entries_lp; i++) begin
                cnt_reg[i] <= '0;
            end
            lp_reg       <= '0;
            long_cnt_reg <= '0;
        end else begin
            for (int i = 0; i < entries_lp; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
            lp_reg       <= lp_next;
            long_cnt_reg <= long_cnt_next;
        end
    end

    // Status outputs depend only on registered state.
    assign long_busy_o = |long_cnt_reg;
    assign empty_o     = ~(|cnt_nz_vec) & ~(|long_cnt_reg);

endmodule
